// File: rtl/spi_pkg.sv
// Constants shared by the SPI receive front end: bus mode, default buffering and byte geometry.
package spi_pkg;
  localparam logic [1:0] SPI_MODE           = 2'd0;
  localparam logic       SCLK_CPOL          = SPI_MODE[1];
  localparam int         DEFAULT_FIFO_DEPTH = 16;
  localparam int         BITS_PER_BYTE      = 8;
  localparam int         BIT_CNT_W          = $clog2(BITS_PER_BYTE);
endpackage

// File: rtl/byte_fifo.sv
// Synchronous show-ahead FIFO; dout is always the head entry and level counts occupancy.
// A push while full is accepted only when a pop of a non-empty FIFO happens in the same cycle.
module byte_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  // Pointers carry one extra bit so that full and empty are distinguishable.
  assign level   = wr_ptr_q - rd_ptr_q;
  assign full    = (level == FULL_LEVEL);
  assign empty   = (level == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
    rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end
  end
endmodule

// File: rtl/spi_byte_rx.sv
// SPI slave: deserialises MOSI bytes into a show-ahead FIFO for the controller and
// shifts tx_byte back on MISO, re-sampling it once per byte.
module spi_byte_rx
  import spi_pkg::*;
#(
  parameter int FIFO_DEPTH  = DEFAULT_FIFO_DEPTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          spi_sclk,
  input  logic                          spi_cs_n,
  input  logic                          spi_mosi,
  output logic                          spi_miso,
  input  logic [BITS_PER_BYTE-1:0]      tx_byte,
  output logic [BITS_PER_BYTE-1:0]      out_byte,
  output logic                          out_valid,
  input  logic                          next,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow
);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(BITS_PER_BYTE - 1);

  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q, settle_q;
  logic sclk_prev_q, cs_prev_q, armed_q;
  logic rise_q, fall_q, mosi_q;
  logic sclk_s, cs_s, settled, cs_idle, rise, fall, cs_fall;

  logic [BIT_CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [BITS_PER_BYTE-1:0] rx_shift_q, rx_shift_d;
  logic [BITS_PER_BYTE-1:0] tx_shift_q, tx_shift_d;
  logic reload_q, reload_d, push_q, push_d, overflow_q, overflow_d;
  logic fifo_full, fifo_empty;

  assign sclk_s  = sclk_sync_q[SYNC_STAGES-1] ^ SCLK_CPOL;
  assign cs_s    = cs_sync_q[SYNC_STAGES-1];
  assign settled = settle_q[SYNC_STAGES-1];
  // Until a settled CS-high is seen after reset, a low CS is a leftover frame and is ignored.
  assign cs_idle = cs_s | ~armed_q;
  assign rise    = ~cs_idle &  sclk_s & ~sclk_prev_q;
  assign fall    = ~cs_idle & ~sclk_s &  sclk_prev_q;
  assign cs_fall = armed_q & cs_prev_q & ~cs_s;

  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      settle_q    <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
      armed_q     <= 1'b0;
      rise_q      <= 1'b0;
      fall_q      <= 1'b0;
      mosi_q      <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      settle_q    <= {settle_q[SYNC_STAGES-2:0], 1'b1};
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
      armed_q     <= armed_q | (settled & cs_s);
      rise_q      <= rise;
      fall_q      <= fall;
      mosi_q      <= mosi_sync_q[SYNC_STAGES-1];
    end
  end

  always_comb begin
    bit_cnt_d  = bit_cnt_q;
    rx_shift_d = rx_shift_q;
    tx_shift_d = tx_shift_q;
    reload_d   = reload_q;
    push_d     = 1'b0;
    overflow_d = overflow_q | (push_q & fifo_full & ~next);
    if (cs_idle) begin
      bit_cnt_d  = '0;
      rx_shift_d = '0;
      tx_shift_d = '0;
      reload_d   = 1'b0;
    end else begin
      if (rise_q) begin
        rx_shift_d = {rx_shift_q[BITS_PER_BYTE-2:0], mosi_q};
        bit_cnt_d  = bit_cnt_q + BIT_CNT_W'(1);
        if (bit_cnt_q == LAST_BIT) begin
          push_d   = 1'b1;
          reload_d = 1'b1;
        end
      end
      // The falling edge closing a byte reloads the status byte instead of shifting.
      if (cs_fall) begin
        tx_shift_d = tx_byte;
      end else if (fall_q) begin
        if (reload_q) begin
          tx_shift_d = tx_byte;
          reload_d   = 1'b0;
        end else begin
          tx_shift_d = tx_shift_q << 1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt_q  <= '0;
      rx_shift_q <= '0;
      tx_shift_q <= '0;
      reload_q   <= 1'b0;
      push_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      bit_cnt_q  <= bit_cnt_d;
      rx_shift_q <= rx_shift_d;
      tx_shift_q <= tx_shift_d;
      reload_q   <= reload_d;
      push_q     <= push_d;
      overflow_q <= overflow_d;
    end
  end

  byte_fifo #(
    .WIDTH (BITS_PER_BYTE),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_q),
    .pop   (next),
    .din   (rx_shift_q),
    .dout  (out_byte),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign out_valid = ~fifo_empty;
  assign overflow  = overflow_q;
  assign spi_miso  = ~cs_idle & tx_shift_q[BITS_PER_BYTE-1];
endmodule

// File: tb/tb_spi_byte_rx.sv
// Directed bench for spi_byte_rx: SPI host model at clk/8 with hand-computed expectations.
module tb_spi_byte_rx;
  logic       clk = 1'b0;
  logic       reset;
  logic       spi_sclk, spi_cs_n, spi_mosi;
  logic       spi_miso;
  logic [7:0] tx_byte;
  logic [7:0] out_byte;
  logic       out_valid;
  logic       pop_next;
  logic [4:0] fifo_level;
  logic       overflow;

  int n_total = 0;
  int n_pass  = 0;
  logic [7:0] rx1, rx2, dummy;

  typedef struct {
    logic [7:0] din;
    logic [7:0] exp_out;
    logic [4:0] exp_level;
  } vec_t;
  vec_t burst [7];

  spi_byte_rx dut (
    .clk        (clk),
    .reset      (reset),
    .spi_sclk   (spi_sclk),
    .spi_cs_n   (spi_cs_n),
    .spi_mosi   (spi_mosi),
    .spi_miso   (spi_miso),
    .tx_byte    (tx_byte),
    .out_byte   (out_byte),
    .out_valid  (out_valid),
    .next       (pop_next),
    .fifo_level (fifo_level),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic cs_low();
    spi_cs_n = 1'b0;
    tick(8);
  endtask

  task automatic cs_high();
    tick(4);
    spi_cs_n = 1'b1;
    tick(8);
  endtask

  task automatic pop_one();
    pop_next = 1'b1;
    tick(1);
    pop_next = 1'b0;
    tick(1);
  endtask

  // mode 1: check push latency on the last bit; 2: pulse next in the push cycle; 3: change tx_byte at bit 3
  task automatic send_bits(input logic [7:0] data, input int nbits, input int mode, output logic [7:0] rx);
    rx = '0;
    for (int k = 0; k < nbits; k++) begin
      int i;
      i = 7 - k;
      if (mode == 3 && i == 3) tx_byte = 8'h42;
      spi_mosi = data[i];
      tick(4);
      rx[i] = spi_miso;
      spi_sclk = 1'b1;
      if (k == 7 && mode == 1) begin
        tick(4);
        check("latency_not_yet_valid", out_valid, 0);
        tick(1);
        check("latency_valid", out_valid, 1);
        check("latency_byte", out_byte, data);
        tick(3);
      end else if (k == 7 && mode == 2) begin
        tick(4);
        pop_next = 1'b1;
        tick(1);
        pop_next = 1'b0;
        tick(3);
      end else begin
        tick(4);
      end
      spi_sclk = 1'b0;
    end
    tick(4);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish, checks passed %0d of %0d", n_pass, n_total);
    $fatal(1);
  end

  initial begin
    burst[0] = '{8'h01, 8'h01, 5'd1};
    burst[1] = '{8'h10, 8'h10, 5'd2};
    burst[2] = '{8'h20, 8'h20, 5'd3};
    burst[3] = '{8'h00, 8'h00, 5'd4};
    burst[4] = '{8'h00, 8'h00, 5'd5};
    burst[5] = '{8'h00, 8'h00, 5'd6};
    burst[6] = '{8'h01, 8'h01, 5'd7};

    reset = 1'b1; spi_sclk = 1'b0; spi_cs_n = 1'b1; spi_mosi = 1'b0;
    tx_byte = 8'h00; pop_next = 1'b0;
    tick(3);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_byte", out_byte, 0);
    check("reset_level", fifo_level, 0);
    check("reset_overflow", overflow, 0);
    check("reset_miso", spi_miso, 0);
    reset = 1'b0;
    tick(4);

    // single byte with exact push latency, then one pop
    cs_low();
    send_bits(8'hA5, 8, 1, dummy);
    check("single_level", fifo_level, 1);
    pop_next = 1'b1;
    tick(1);
    pop_next = 1'b0;
    check("single_pop_empty", out_valid, 0);
    cs_high();

    // burst without pops, then drain every 2 cycles
    cs_low();
    for (int v = 0; v < 7; v++) begin
      send_bits(burst[v].din, 8, 0, dummy);
      check("burst_level", fifo_level, burst[v].exp_level);
    end
    cs_high();
    for (int v = 0; v < 7; v++) begin
      check("burst_order", out_byte, burst[v].exp_out);
      pop_one();
    end
    check("burst_drained", out_valid, 0);

    // overflow: 17th byte dropped while full
    cs_low();
    for (int v = 0; v < 16; v++) send_bits(8'h10 + 8'(v), 8, 0, dummy);
    check("full_level", fifo_level, 16);
    check("full_no_overflow", overflow, 0);
    send_bits(8'hFF, 8, 0, dummy);
    check("ovf_flag", overflow, 1);
    check("ovf_level", fifo_level, 16);
    check("ovf_head", out_byte, 8'h10);
    cs_high();
    check("ovf_sticky", overflow, 1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("ovf_cleared_by_reset", overflow, 0);
    tick(4);

    // push while full with an aligned pop: both happen
    cs_low();
    for (int v = 0; v < 16; v++) send_bits(8'h10 + 8'(v), 8, 0, dummy);
    send_bits(8'hFF, 8, 2, dummy);
    check("pushpop_no_overflow", overflow, 0);
    check("pushpop_level", fifo_level, 16);
    check("pushpop_head", out_byte, 8'h11);
    cs_high();
    for (int v = 0; v < 15; v++) pop_one();
    check("pushpop_tail", out_byte, 8'hFF);
    check("pushpop_tail_level", fifo_level, 1);
    pop_one();
    check("pushpop_drained", out_valid, 0);

    // partial byte discarded on CS rise
    cs_low();
    send_bits(8'hF8, 5, 0, dummy);
    cs_high();
    check("partial_dropped", fifo_level, 0);
    cs_low();
    send_bits(8'h3C, 8, 0, dummy);
    cs_high();
    check("partial_then_level", fifo_level, 1);
    check("partial_then_byte", out_byte, 8'h3C);
    pop_one();

    // MISO: status re-sampled once per byte
    tx_byte = 8'h81;
    tick(2);
    cs_low();
    send_bits(8'h12, 8, 3, rx1);
    send_bits(8'h34, 8, 0, rx2);
    cs_high();
    check("miso_byte1", rx1, 8'h81);
    check("miso_byte2", rx2, 8'h42);
    check("miso_idle", spi_miso, 0);
    check("miso_rx_level", fifo_level, 2);
    check("miso_rx_first", out_byte, 8'h12);
    pop_one();
    check("miso_rx_second", out_byte, 8'h34);
    pop_one();

    // reset mid-byte with three bytes queued
    tx_byte = 8'hFF;
    tick(2);
    cs_low();
    send_bits(8'h11, 8, 0, dummy);
    send_bits(8'h22, 8, 0, dummy);
    send_bits(8'h33, 8, 0, dummy);
    send_bits(8'hA0, 4, 0, dummy);
    check("pre_reset_level", fifo_level, 3);
    check("pre_reset_miso", spi_miso, 1);
    reset = 1'b1;
    tick(1);
    check("midreset_out_valid", out_valid, 0);
    check("midreset_out_byte", out_byte, 0);
    check("midreset_level", fifo_level, 0);
    check("midreset_overflow", overflow, 0);
    check("midreset_miso", spi_miso, 0);
    reset = 1'b0;
    tick(1);
    send_bits(8'hC0, 4, 0, dummy);
    send_bits(8'h99, 8, 0, dummy);
    check("no_rx_before_new_cs", fifo_level, 0);
    check("no_miso_before_new_cs", spi_miso, 0);
    cs_high();
    cs_low();
    send_bits(8'h55, 8, 0, dummy);
    cs_high();
    check("post_reset_level", fifo_level, 1);
    check("post_reset_byte", out_byte, 8'h55);
    check("post_reset_valid", out_valid, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/spi_byte_rx.md
# spi_byte_rx

SPI slave front end that feeds the command controller. It deserialises MOSI bytes from the host MCU into a small show-ahead FIFO and presents the head byte on `out_byte`/`out_valid`, popping on the controller's one-cycle `next` pulse. It also shifts the controller's `spi_output` status byte back to the host on MISO. It sits between the external SPI pins and the controller's `in_byte`/`in_valid`/`next` ports.

## Interface
- `FIFO_DEPTH`, 16: receive FIFO entries; must be a power of two, ≥ 2.
- `SYNC_STAGES`, 2: synchroniser flops on `spi_sclk`, `spi_cs_n` and `spi_mosi`.

- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high.
- `spi_sclk`  in  1  SPI clock, asynchronous. Mode 0, at most clk/8.
- `spi_cs_n`  in  1  chip select, active low, asynchronous.
- `spi_mosi`  in  1  serial data in, MSB first.
- `spi_miso`  out  1  serial data out, MSB first.
- `tx_byte`  in  8  byte to return to the host; driven by the controller's `spi_output`.
- `out_byte`  out  8  FIFO head byte; goes to the controller's `in_byte`.
- `out_valid`  out  1  FIFO non-empty; goes to the controller's `in_valid`.
- `next`  in  1  one-cycle pop strobe from the controller.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- `overflow`  out  1  sticky flag: a received byte was dropped.

## Operation
- **Input synchronisation:** `sclk`, `cs_n` and `mosi` each pass through `SYNC_STAGES` flops. Edge detect uses one further registered copy of `sclk` and of `cs_n`.
- **Frame control:**
  - Synchronised `cs_n` high: bit counter held at 0, RX shift register cleared, MISO shift register idle.
  - A partial byte when CS rises is discarded and not pushed.
- **Receive:**
  - On each detected `sclk` rising edge with CS low: shift in the synchronised MOSI, MSB first; bit counter increments modulo 8.
  - When the counter wraps 7→0, the assembled byte is pushed in the following cycle.
- **Transmit:**
  - On the detected CS falling edge, `tx_byte` is loaded and `spi_miso` presents bit 7.
  - On each detected `sclk` falling edge the register shifts left.
  - On the falling edge that follows the 8th rising edge of a byte, `tx_byte` is reloaded instead of shifted. This re-samples the controller status once per byte.
  - `spi_miso` is 0 while CS is high.
- **FIFO:** show-ahead.
  - `out_byte` is always the head entry; `out_valid = (level != 0)`.
  - `next` with `out_valid` low is ignored.
- **Push while full:**
  - Without `next` in the same cycle: byte dropped, `overflow` set, set until reset.
  - With `next` in the same cycle: pop and push both take effect and the level is unchanged.
- **Pointers:** wrap modulo `FIFO_DEPTH`. `fifo_level` is the pointer difference with one extra bit, so full reads as `FIFO_DEPTH`.
- **Reset:**
  - Values: `out_valid` 0, `out_byte` 0, `fifo_level` 0, `overflow` 0, `spi_miso` 0. Pointers, bit counter and shift registers 0. Synchroniser flops: `sclk` 0, `cs_n` 1, `mosi` 0.
  - Reset mid-frame: the in-progress byte and all FIFO contents are discarded. Reception resumes only after a new CS falling edge.

## Timing
- **Push latency:** the synchronised 8th rising edge is detected in cycle t. Shift occurs at t+1, push at t+2, and `out_valid`/`out_byte` are valid at t+3. From the raw `sclk` edge this is `SYNC_STAGES`+3 cycles.
- **Pop:** `next` in cycle t pops the head. The new head or `out_valid`=0 is visible at t+1. The controller ignores the cycle after `next`, so back-to-back bytes stream one every two cycles.
- **MISO:** changes `SYNC_STAGES`+2 cycles after a raw `sclk` falling edge. At clk/8 this meets host setup time before the next rising edge.
- **Throughput:** a byte time at max SCLK is 64 clk, which exceeds the controller's worst-case drain. Overflow occurs only while the controller stalls in a wait state.

## Structure
- **Shared package `spi_pkg`:** SPI mode constant, default `FIFO_DEPTH`, bits-per-byte constant (8).
- **Sub-module `byte_fifo`:** synchronous show-ahead FIFO with parameters `WIDTH` and `DEPTH`, and ports `push`, `pop`, `din`, `dout`, `level`, `full`, `empty`. It implements the simultaneous push/pop-when-full rule. It is reusable elsewhere in the design.
- **`spi_byte_rx`** contains the synchronisers, edge detection, bit counter, RX/TX shift registers and overflow flag.

## Test plan
- **Single byte:** CS low, send 0xA5 at clk/8, CS high → `out_valid` rises `SYNC_STAGES`+3 cycles after the 8th edge with `out_byte`=0xA5 and `fifo_level`=1. One `next` pulse → `out_valid`=0 the next cycle.
- **Burst:** send 0x01 0x10 0x20 0x00 0x00 0x00 0x01 with no pops → `fifo_level`=7. Then pop every 2 cycles → bytes emerge in order, then `out_valid`=0.
- **Overflow:**
  - Fill 16 bytes with no pops, then send 0xFF → `overflow`=1, `fifo_level`=16, head still the first byte.
  - Repeat with a `next` pulse aligned to the push cycle → no overflow, 0xFF becomes the last entry.
- **Partial byte:** CS low, 5 clocks, CS high, then a full 0x3C frame → only 0x3C is received.
- **MISO:** `tx_byte`=0x81 before CS falls; change it to 0x42 during bit 3 → host reads 0x81 for byte 1 and 0x42 for byte 2.
- **Reset mid-operation:** reset asserted mid-byte with 3 bytes queued → all outputs return to reset values the next cycle. A following clean frame 0x55 is received correctly.
